udp_payload_mgr: RTL and testbench
==================================

// Module: udp_payload_mgr
// PURPOSE
// - Owns the write port of the UDP TX/RX payload RAM and the TX length registers.
// - After reset, writes a default payload, taken from a parameter table, into the RAM.
// - In loopback mode, passes received-payload writes from the UDP core through to the RAM and echoes validated RX lengths.
// - In fixed mode, always transmits the default payload and default lengths.
// PARAMETERS
// - DATA_W       32       RAM word width; must be a multiple of 8.
// - ADDR_W       9        RAM address width.
// - INIT_WORDS   5        Number of default payload words; range 1..2**ADDR_W-INIT_BASE.
// - INIT_BASE    1        RAM address of the first default word.
// - INIT_DATA    {...}    INIT_WORDS*DATA_W packed table. Word k is held in bits [k*DATA_W +: DATA_W].
// - DEF_DATA_LEN 16'd28   Default UDP length: 8-byte header + payload bytes.
// - DEF_TOT_LEN  16'd48   Default IP total length: DEF_DATA_LEN + 20.
// - MAX_DATA_LEN 16'd2052 Largest accepted rx_data_length; 8 + (2**ADDR_W-INIT_BASE)*DATA_W/8.
// PORTS
// - e_rxc            in   1        GMII RX clock, 125 MHz; the only clock.
// - reset_n          in   1        Asynchronous, active-low reset.
// - mode_loopback    in   1        1 = echo received data; 0 = fixed default payload.
// - reinit           in   1        Single-cycle pulse: rewrite the default payload and restore default lengths.
// - rx_wr_en         in   1        Received-payload word valid (from the UDP core).
// - rx_wr_addr       in   ADDR_W   Address of the received word.
// - rx_wr_data       in   DATA_W   Received word.
// - data_receive     in   1        Frame-complete pulse from the UDP core.
// - rx_data_length   in   16       UDP length of the received frame.
// - rx_total_length  in   16       IP total length of the received frame.
// - ram_wea          out  1        RAM port-A write enable.
// - ram_addra        out  ADDR_W   RAM port-A address.
// - ram_dina         out  DATA_W   RAM port-A write data.
// - tx_data_length   out  16       UDP length handed to the TX path.
// - tx_total_length  out  16       IP total length handed to the TX path.
// - init_done        out  1        High while state is RUN.
// - len_err          out  1        One-cycle pulse when a received frame is rejected.
// BEHAVIOUR
// Reset values
// - ram_wea=0, ram_addra=0, ram_dina=0.
// - tx_data_length=DEF_DATA_LEN, tx_total_length=DEF_TOT_LEN.
// - init_done=0, len_err=0.
// - The FSM enters INIT with word index idx=0.
// Registering
// - All outputs are registered on posedge e_rxc.
// - RAM port outputs lag the input or table word by exactly 1 cycle.
// FSM states
// - INIT: each cycle outputs wea=1, addra=INIT_BASE+idx, dina=INIT_DATA[idx], then increments idx.
//   - INIT_WORDS writes occur on consecutive cycles.
//   - After the last write, go to RUN; init_done rises in the cycle after the last write.
//   - rx_wr_en and data_receive are ignored in INIT.
// - RUN, mode_loopback=1:
//   - Pass-through: wea=rx_wr_en, addra=rx_wr_addr, dina=rx_wr_data.
//   - When wea=0, addra and dina hold their previous values.
// - RUN, mode_loopback=0:
//   - wea=0 and rx writes are dropped.
//   - Lengths hold their defaults; data_receive is ignored.
// Length validation
// - Applies to a data_receive pulse in RUN with loopback active.
// - A frame is valid when all three hold:
//   - 8 <= rx_data_length <= MAX_DATA_LEN;
//   - rx_total_length == rx_data_length + 20, compared at 16-bit width;
//   - the +20 addition does not overflow.
// - Valid frame: latch both RX lengths into the tx_* outputs on the next edge.
// - Invalid frame:
//   - Pulse len_err for 1 cycle.
//   - Restore the default lengths.
//   - Enter INIT at idx=0, because the RAM may hold a partial payload.
// Re-initialisation triggers
// - reinit=1 in any state: enter INIT at idx=0 and restore the default lengths.
//   - A reinit during INIT restarts from word 0.
// - A 1->0 transition of mode_loopback while in RUN has the same effect as reinit.
// - mode_loopback is sampled every cycle.
// Simultaneous events
// - reinit beats data_receive: the lengths go to defaults and len_err stays 0.
// - When rx_wr_en and data_receive coincide, the write still issues.
// Reset mid-operation
// - Asynchronous reset forces all reset values immediately.
// - The INIT sequence restarts from idx=0 after reset_n deasserts.
// TESTING
// - Release reset -> ram_wea=1 for 5 consecutive cycles.
//   - Addresses 1..5 carry the "HELLO ALINX AX7100\n\r" words 0x48454C4C..0x30300A0D.
//   - init_done rises next cycle; tx lengths read 28/48.
// - Loopback, rx_wr_en burst to addresses 1..3, then data_receive with lengths 20/40:
//   - identical RAM writes appear 1 cycle late;
//   - tx lengths become 20/40; len_err=0.
// - data_receive with lengths 20/41, then separately 4/24, then 3000/3020:
//   - each gives a 1-cycle len_err;
//   - lengths return to 28/48;
//   - the 5-word INIT rewrite follows.
// - mode_loopback=0, then rx_wr_en activity plus data_receive 20/40:
//   - the 1->0 edge triggers one 5-word INIT rewrite;
//   - after that INIT, ram_wea stays 0;
//   - lengths stay 28/48.
// - Pulse reinit at INIT write 3 -> writes restart at address 1, for 5 writes total after the pulse.
// - reinit and data_receive (20/40) in the same cycle -> lengths 28/48, len_err=0, INIT runs.
// - Assert reset_n=0 mid-INIT -> outputs go to reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/udp_payload_mgr_if.sv
// Bus bundle between the UDP core, the payload RAM write port and the TX
// length registers. The manager is the slave side; the UDP core (or a bench)
// is the master side.
`timescale 1ns/1ps
interface udp_payload_mgr_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) ();
  logic              rx_wr_en;
  logic [ADDR_W-1:0] rx_wr_addr;
  logic [DATA_W-1:0] rx_wr_data;
  logic              data_receive;
  logic [15:0]       rx_data_length;
  logic [15:0]       rx_total_length;
  logic              ram_wea;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic [15:0]       tx_data_length;
  logic [15:0]       tx_total_length;

  modport slave (
    input  rx_wr_en, rx_wr_addr, rx_wr_data, data_receive,
    input  rx_data_length, rx_total_length,
    output ram_wea, ram_addra, ram_dina, tx_data_length, tx_total_length
  );

  modport master (
    output rx_wr_en, rx_wr_addr, rx_wr_data, data_receive,
    output rx_data_length, rx_total_length,
    input  ram_wea, ram_addra, ram_dina, tx_data_length, tx_total_length
  );
endinterface

// File: rtl/udp_payload_mgr.sv
// UDP payload manager: owns the payload RAM write port and the TX length
// registers. Writes a default payload after reset or re-initialisation,
// then either echoes received frames (loopback) or keeps the defaults.
`timescale 1ns/1ps
module udp_payload_mgr #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int INIT_WORDS = 5,
  parameter int INIT_BASE = 1,
  parameter logic [INIT_WORDS*DATA_W-1:0] INIT_DATA = {
    32'h30300A0D, 32'h41583731, 32'h494E5820, 32'h4F20414C, 32'h48454C4C
  },
  parameter logic [15:0] DEF_DATA_LEN = 16'd28,
  parameter logic [15:0] DEF_TOT_LEN = 16'd48,
  parameter logic [15:0] MAX_DATA_LEN = 16'd2052
) (
  input  logic               e_rxc,
  input  logic               reset_n,
  input  logic               mode_loopback,
  input  logic               reinit,
  udp_payload_mgr_if.slave   bus,
  output logic               init_done,
  output logic               len_err
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(INIT_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(INIT_BASE);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              mode_prev_q;

  logic [16:0]       len_sum;
  logic              frame_valid;
  logic              frame_seen;
  logic              mode_fall;
  logic              restart;
  logic [DATA_W-1:0] init_word;

  logic              wea_d;
  logic [ADDR_W-1:0] addra_d;
  logic [DATA_W-1:0] dina_d;
  logic [15:0]       tx_dlen_d, tx_tlen_d;
  logic              init_done_d, len_err_d;

  // Frame validation, mode-drop detection and the combined restart request
  always_comb begin
    len_sum     = {1'b0, bus.rx_data_length} + 17'd20;
    frame_valid = (bus.rx_data_length >= 16'd8) &&
                  (bus.rx_data_length <= MAX_DATA_LEN) &&
                  !len_sum[16] &&
                  (len_sum[15:0] == bus.rx_total_length);
    frame_seen  = (state_q == RUN) && mode_loopback && bus.data_receive;
    mode_fall   = (state_q == RUN) && mode_prev_q && !mode_loopback;
    restart     = reinit || mode_fall || (frame_seen && !frame_valid);
    init_word   = INIT_DATA[int'(idx_q)*DATA_W +: DATA_W];
  end

  // State register: FSM state, default-word index and previous mode sample
  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      idx_q       <= '0;
      mode_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_prev_q <= mode_loopback;
    end
  end

  // Next state: any restart returns to word 0, INIT walks the table then runs
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (restart) begin
      state_d = INIT;
      idx_d   = '0;
    end else if (state_q == INIT) begin
      if (idx_q == LAST_IDX) begin
        state_d = RUN;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Output decode: next values of the registered RAM port and length outputs
  always_comb begin
    wea_d       = 1'b0;
    addra_d     = bus.ram_addra;
    dina_d      = bus.ram_dina;
    tx_dlen_d   = bus.tx_data_length;
    tx_tlen_d   = bus.tx_total_length;
    len_err_d   = frame_seen && !frame_valid && !reinit;
    init_done_d = (state_q == RUN) && !restart;
    if (state_q == INIT) begin
      if (!reinit) begin
        wea_d   = 1'b1;
        addra_d = BASE_ADDR + idx_q;
        dina_d  = init_word;
      end
    end else if (mode_loopback && bus.rx_wr_en) begin
      wea_d   = 1'b1;
      addra_d = bus.rx_wr_addr;
      dina_d  = bus.rx_wr_data;
    end
    if (restart) begin
      tx_dlen_d = DEF_DATA_LEN;
      tx_tlen_d = DEF_TOT_LEN;
    end else if (frame_seen && frame_valid) begin
      tx_dlen_d = bus.rx_data_length;
      tx_tlen_d = bus.rx_total_length;
    end
  end

  // Output register: every output is a flop so the RAM port lags by one cycle
  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      bus.ram_wea         <= 1'b0;
      bus.ram_addra       <= '0;
      bus.ram_dina        <= '0;
      bus.tx_data_length  <= DEF_DATA_LEN;
      bus.tx_total_length <= DEF_TOT_LEN;
      init_done           <= 1'b0;
      len_err             <= 1'b0;
    end else begin
      bus.ram_wea         <= wea_d;
      bus.ram_addra       <= addra_d;
      bus.ram_dina        <= dina_d;
      bus.tx_data_length  <= tx_dlen_d;
      bus.tx_total_length <= tx_tlen_d;
      init_done           <= init_done_d;
      len_err             <= len_err_d;
    end
  end

endmodule

// File: tb/tb_udp_payload_mgr.sv
// Self-checking bench for udp_payload_mgr. A queue-based reference model
// predicts RAM writes into a scoreboard and tracks the expected lengths and
// status flags; a monitor compares on every falling edge.
`timescale 1ns/1ps
module tb_udp_payload_mgr;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int MAX_LEN = 2052;

  logic e_rxc = 1'b0;
  logic reset_n = 1'b1;
  logic mode_loopback = 1'b0;
  logic reinit = 1'b0;
  logic init_done;
  logic len_err;

  udp_payload_mgr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  udp_payload_mgr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .e_rxc         (e_rxc),
    .reset_n       (reset_n),
    .mode_loopback (mode_loopback),
    .reinit        (reinit),
    .bus           (bus),
    .init_done     (init_done),
    .len_err       (len_err)
  );

  // 125 MHz receive clock
  initial forever #4 e_rxc = ~e_rxc;

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  // "HELLO ALINX AX7100\n\r" split into big-endian 32-bit words
  logic [31:0] hello_words [5] = '{32'h48454C4C, 32'h4F20414C, 32'h494E5820,
                                   32'h41583731, 32'h30300A0D};

  wr_t exp_q[$];
  wr_t pending[$];

  logic        exp_wea;
  logic [8:0]  exp_addr;
  logic [31:0] exp_data;
  logic [15:0] exp_dlen;
  logic [15:0] exp_tlen;
  logic        exp_done;
  logic        exp_err;
  logic        model_mode_prev;

  int compared = 0;
  int mismatched = 0;

  // Queue the five default words the manager must write after a restart
  function automatic void loadDefault();
    wr_t w;
    pending.delete();
    for (int k = 0; k < 5; k++) begin
      w.addr = 9'(1 + k);
      w.data = hello_words[k];
      pending.push_back(w);
    end
  endfunction

  // A frame is acceptable when its UDP length is in range and the IP length
  // is exactly 20 bytes more
  function automatic bit frameOk(input int dl, input int tl);
    return (dl >= 8) && (dl <= MAX_LEN) && (tl == dl + 20);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: idle means no default words left to write
  bit  m_running, m_fall, m_seen, m_ok, m_bad, m_restart;
  wr_t mw;
  initial begin
    loadDefault();
    exp_wea = 0; exp_addr = 0; exp_data = 0;
    exp_dlen = 16'd28; exp_tlen = 16'd48;
    exp_done = 0; exp_err = 0; model_mode_prev = 0;
    forever begin
      @(posedge e_rxc or negedge reset_n);
      if (!reset_n) begin
        exp_q.delete();
        loadDefault();
        exp_wea = 0; exp_addr = 0; exp_data = 0;
        exp_dlen = 16'd28; exp_tlen = 16'd48;
        exp_done = 0; exp_err = 0; model_mode_prev = 0;
      end else begin
        m_running = (pending.size() == 0);
        m_fall    = m_running && model_mode_prev && !mode_loopback;
        m_seen    = m_running && mode_loopback && bus.data_receive;
        m_ok      = frameOk(int'(bus.rx_data_length), int'(bus.rx_total_length));
        m_bad     = m_seen && !m_ok && !reinit;
        m_restart = reinit || m_fall || (m_seen && !m_ok);
        exp_wea   = 0;
        if (m_running) begin
          if (mode_loopback && bus.rx_wr_en) begin
            mw.addr = bus.rx_wr_addr;
            mw.data = bus.rx_wr_data;
            exp_q.push_back(mw);
            exp_wea = 1; exp_addr = mw.addr; exp_data = mw.data;
          end
        end else if (!reinit) begin
          mw = pending.pop_front();
          exp_q.push_back(mw);
          exp_wea = 1; exp_addr = mw.addr; exp_data = mw.data;
        end
        if (m_restart) begin
          exp_dlen = 16'd28; exp_tlen = 16'd48;
        end else if (m_seen && m_ok) begin
          exp_dlen = bus.rx_data_length; exp_tlen = bus.rx_total_length;
        end
        exp_err  = m_bad;
        exp_done = m_running && !m_restart;
        if (m_restart) loadDefault();
        model_mode_prev = mode_loopback;
      end
    end
  end

  // Monitor: pops the scoreboard on each DUT write, checks status every cycle
  wr_t sw;
  initial forever begin
    @(negedge e_rxc);
    checkOutput("ram_wea", bus.ram_wea, exp_wea);
    if (bus.ram_wea) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: addr %0h data %0h, scoreboard empty",
                 bus.ram_addra, bus.ram_dina);
      end else begin
        sw = exp_q.pop_front();
        checkOutput("wr_addr", bus.ram_addra, sw.addr);
        checkOutput("wr_data", bus.ram_dina, sw.data);
      end
    end
    checkOutput("ram_addra", bus.ram_addra, exp_addr);
    checkOutput("ram_dina", bus.ram_dina, exp_data);
    checkOutput("tx_data_length", bus.tx_data_length, exp_dlen);
    checkOutput("tx_total_length", bus.tx_total_length, exp_tlen);
    checkOutput("init_done", init_done, exp_done);
    checkOutput("len_err", len_err, exp_err);
  end

  task automatic applyStimulus(input logic ml, input logic rn, input logic we,
                               input logic [8:0] wa, input logic [31:0] wd,
                               input logic dr, input logic [15:0] dl,
                               input logic [15:0] tl);
    @(negedge e_rxc);
    mode_loopback       = ml;
    reinit              = rn;
    bus.rx_wr_en        = we;
    bus.rx_wr_addr      = wa;
    bus.rx_wr_data      = wd;
    bus.data_receive    = dr;
    bus.rx_data_length  = dl;
    bus.rx_total_length = tl;
  endtask

  task automatic idle(input int n, input logic ml);
    repeat (n) applyStimulus(ml, 1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 16'd0, 16'd0);
  endtask

  // Overall time bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [15:0] r_dl, r_tl;
  initial begin
    bus.rx_wr_en = 0; bus.rx_wr_addr = 0; bus.rx_wr_data = 0;
    bus.data_receive = 0; bus.rx_data_length = 0; bus.rx_total_length = 0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge e_rxc);
    reset_n = 1'b1;
    $display("[TB] reset released, default payload expected");
    idle(8, 1'b1);

    $display("[TB] loopback burst and valid frame");
    for (int i = 1; i <= 3; i++)
      applyStimulus(1, 0, 1, 9'(i), 32'hA5A50000 + 32'(i), 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 16'd20, 16'd40);
    idle(3, 1'b1);

    $display("[TB] rejected frames");
    applyStimulus(1, 0, 0, 0, 0, 1, 16'd20, 16'd41);
    idle(8, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 1, 16'd4, 16'd24);
    idle(8, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 1, 16'd3000, 16'd3020);
    idle(8, 1'b1);

    $display("[TB] fixed mode");
    for (int i = 0; i < 12; i++)
      applyStimulus(0, 0, 1, 9'(20 + i), 32'hC0DE0000 + 32'(i), i == 8, 16'd20, 16'd40);
    idle(3, 1'b0);
    idle(3, 1'b1);

    $display("[TB] reinit during INIT");
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    idle(3, 1'b1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    idle(8, 1'b1);

    $display("[TB] reinit beats data_receive");
    applyStimulus(1, 0, 0, 0, 0, 1, 16'd100, 16'd120);
    idle(1, 1'b1);
    applyStimulus(1, 1, 0, 0, 0, 1, 16'd20, 16'd40);
    idle(8, 1'b1);

    $display("[TB] asynchronous reset mid-INIT");
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    idle(2, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_wea", bus.ram_wea, 1'b0);
    checkOutput("async_rst_addra", bus.ram_addra, 9'd0);
    checkOutput("async_rst_dina", bus.ram_dina, 32'd0);
    checkOutput("async_rst_dlen", bus.tx_data_length, 16'd28);
    checkOutput("async_rst_tlen", bus.tx_total_length, 16'd48);
    checkOutput("async_rst_done", init_done, 1'b0);
    checkOutput("async_rst_err", len_err, 1'b0);
    @(negedge e_rxc);
    reset_n = 1'b1;
    idle(8, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: begin r_dl = 16'($urandom_range(8, MAX_LEN)); r_tl = r_dl + 16'd20; end
        1: begin r_dl = 16'($urandom_range(8, MAX_LEN)); r_tl = r_dl + 16'd21; end
        2: begin r_dl = 16'($urandom_range(0, 7)); r_tl = r_dl + 16'd20; end
        default: begin r_dl = 16'($urandom_range(MAX_LEN + 1, 65535)); r_tl = r_dl + 16'd20; end
      endcase
      applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 99) == 0,
                    1'($urandom_range(0, 1)), 9'($urandom), $urandom,
                    $urandom_range(0, 15) == 0, r_dl, r_tl);
    end
    idle(10, 1'b1);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
